// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus drain FSM feeding the UART transmitter.
// Ports: wr_en/wr_data/flush/ovf_clr in; full/empty/level/overflow/idle status; tx_* handshake.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          ovf_clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          idle,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  input  logic          tx_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          push;
  logic          drop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign idle  = empty & (state == S_IDLE) & ~tx_start;

  // A pop frees a slot this cycle, so a write to a full FIFO is still taken.
  assign push = wr_en & ~flush & (~full | pop);
  assign drop = wr_en & ~flush & full & ~pop;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty && !flush) begin
          pop      = 1'b1;
          state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (tx_busy) state_nx = S_WAIT;
      end
      // Leaving on the first done cycle means a lingering second
      // done cycle lands in IDLE, where it is ignored.
      S_WAIT: begin
        if (tx_done && !tx_busy) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: queue-based model, stub transmitter, directed tests.
// Compares all DUT outputs every falling edge; literal checks pin the model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int BUSY  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en, flush, ovf_clr;
  logic [7:0]  wr_data;
  logic        full, empty, overflow, idle, tx_start;
  logic [AW:0] level;
  logic [7:0]  tx_data;
  logic        tx_busy, tx_done;
  logic        hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .ovf_clr(ovf_clr), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .idle(idle),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: queue of stored bytes plus a launch phase tracker.
  byte unsigned q[$];
  byte unsigned launched[$];
  int          m_st;
  logic        m_start;
  logic [7:0]  m_data;
  logic        m_ovf;
  bit          pop_now, full_now;

  initial begin
    q.delete(); m_st = 0; m_start = 0; m_data = 0; m_ovf = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete(); m_st = 0; m_start = 0; m_data = 0; m_ovf = 0;
      end else begin
        full_now = (q.size() == DEPTH);
        pop_now  = (m_st == 0) && (q.size() != 0) && !flush;
        m_start  = pop_now;
        if (flush) q.delete();
        else begin
          if (pop_now) m_data = q.pop_front();
          if (wr_en && (!full_now || pop_now)) q.push_back(wr_data);
        end
        if (wr_en && !flush && full_now && !pop_now) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        case (m_st)
          0: if (pop_now) m_st = 1;
          1: if (tx_busy) m_st = 2;
          2: if (tx_done && !tx_busy) m_st = 0;
          default: m_st = 0;
        endcase
      end
    end
  end

  // Stub transmitter: busy for BUSY cycles, then done held two cycles.
  int bcnt, dcnt;
  initial begin
    tx_busy = 0; tx_done = 0; bcnt = 0; dcnt = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        tx_busy = 0; tx_done = 0; bcnt = 0; dcnt = 0;
      end else if (hold) begin
        tx_busy = 1; tx_done = 0; bcnt = 1;
      end else begin
        if (tx_start) bcnt = BUSY;
        if (bcnt > 0) begin
          tx_busy = 1; tx_done = 0; bcnt--;
          if (bcnt == 0) dcnt = 2;
        end else if (dcnt > 0) begin
          tx_busy = 0; tx_done = 1; dcnt--;
        end else begin
          tx_busy = 0; tx_done = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cyc_level", 32'(level), q.size());
    chk("cyc_full", full, q.size() == DEPTH);
    chk("cyc_empty", empty, q.size() == 0);
    chk("cyc_ovf", overflow, m_ovf);
    chk("cyc_start", tx_start, m_start);
    chk("cyc_data", tx_data, m_data);
    chk("cyc_idle", idle, (q.size() == 0) && m_st == 0 && !m_start);
    if (tx_start) launched.push_back(tx_data);
  end

  task automatic wr(input logic [7:0] b);
    wr_en = 1; wr_data = b;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    while (!tx_start && n < lim) begin @(negedge clk); n++; end
    chk("start_seen", tx_start, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!idle && n < lim) begin @(negedge clk); n++; end
    chk("idle_seen", idle, 1);
  endtask

  task automatic wait_mst(input int st, input int sz, input int lim);
    int n = 0;
    while (!(m_st == st && (sz < 0 || q.size() == sz)) && n < lim) begin
      @(negedge clk); n++;
    end
    chk("phase_seen", m_st == st, 1);
  endtask

  int n;
  byte unsigned exp_b[4];

  initial begin
    wr_en = 0; wr_data = 0; flush = 0; ovf_clr = 0; hold = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_idle", idle, 1);
    chk("rst_start", tx_start, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1;
    @(negedge clk);

    // Single byte
    launched.delete();
    wr(8'h55);
    wait_start(4, n);
    chk("t1_latency", n <= 1, 1);
    chk("t1_data", tx_data, 8'h55);
    wait_idle(40);
    chk("t1_level", 32'(level), 0);
    chk("t1_count", launched.size(), 1);

    // Burst behind a byte in flight
    launched.delete();
    wr(8'h40);
    wait_start(4, n);
    wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    wr_en = 0;
    chk("t2_level3", 32'(level), 3);
    wait_idle(200);
    exp_b[0] = 8'h40; exp_b[1] = 8'h41; exp_b[2] = 8'h42; exp_b[3] = 8'h43;
    chk("t2_count", launched.size(), 4);
    for (int i = 0; i < 4 && i < launched.size(); i++)
      chk("t2_order", launched[i], exp_b[i]);

    // Overflow with the transmitter stalled
    launched.delete();
    hold = 1;
    wr_en = 1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      wr_data = 8'(i);
      @(negedge clk);
    end
    wr_en = 0;
    chk("t3_full", full, 1);
    chk("t3_level", 32'(level), DEPTH);
    chk("t3_ovf", overflow, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("t3_ovf_clr", overflow, 0);

    // Write into a full FIFO on the pop cycle
    hold = 0;
    wait_mst(0, DEPTH, 40);
    wr(8'hA5);
    chk("t4_level", 32'(level), DEPTH);
    chk("t4_ovf", overflow, 0);
    chk("t4_start", tx_start, 1);
    wait_idle(400);
    chk("t4_count", launched.size(), DEPTH + 2);
    for (int i = 0; i < DEPTH + 1 && i < launched.size(); i++)
      chk("t4_byte", launched[i], i);
    if (launched.size() == DEPTH + 2)
      chk("t4_last", launched[DEPTH + 1], 8'hA5);

    // Flush with one in flight and five queued
    wr_en = 1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h60 + 8'(i);
      @(negedge clk);
    end
    wr_en = 0;
    wait_mst(2, -1, 10);
    chk("t5_level5", 32'(level), 5);
    flush = 1;
    @(negedge clk);
    flush = 0;
    n = launched.size();
    repeat (40) @(negedge clk);
    chk("t5_no_launch", launched.size(), n);
    chk("t5_level", 32'(level), 0);
    chk("t5_empty", empty, 1);
    chk("t5_idle", idle, 1);

    // Asynchronous reset mid-frame
    wr(8'h77);
    wait_mst(2, -1, 10);
    #2 rst_n = 0;
    #1;
    chk("t6_data", tx_data, 8'h00);
    chk("t6_start", tx_start, 0);
    chk("t6_idle", idle, 1);
    chk("t6_empty", empty, 1);
    chk("t6_level", 32'(level), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    wr(8'h88);
    wait_start(4, n);
    chk("t6_relaunch", tx_data, 8'h88);
    wait_idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
